// File: rtl/cfa_pkg.sv
// cfa_pkg: shared types for the CFA gradient scheduler.
// Scheduler states, window geometry and the window tag carried through the pipe.
package cfa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sched_state_t;

  localparam int CFA_WIN  = 5;
  localparam int CFA_HALF = 2;
  localparam int CFA_CW   = 16;

  typedef struct packed {
    logic              valid;
    logic [CFA_CW-1:0] x;
    logic [CFA_CW-1:0] y;
  } grad_tag_t;

endpackage

// File: rtl/cfa_tag_pipe.sv
// cfa_tag_pipe: LAT-deep window tag shift register, no backpressure.
// Ports: clk, rst_n, flush_i (sync clear of valids), tag_i, tag_o, empty_o.
module cfa_tag_pipe
  import cfa_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush_i,
  input  grad_tag_t tag_i,
  output grad_tag_t tag_o,
  output logic      empty_o
);

  grad_tag_t stg_q [LAT];
  grad_tag_t stg_d [LAT];

  // Coordinates only advance with a valid tag so the output
  // stage keeps the last reported window between results.
  always_comb begin
    stg_d = stg_q;
    stg_d[0].valid = tag_i.valid;
    if (tag_i.valid) begin
      stg_d[0].x = tag_i.x;
      stg_d[0].y = tag_i.y;
    end
    for (int i = 1; i < LAT; i++) begin
      stg_d[i].valid = stg_q[i-1].valid;
      if (stg_q[i-1].valid) begin
        stg_d[i].x = stg_q[i-1].x;
        stg_d[i].y = stg_q[i-1].y;
      end
    end
    if (flush_i) begin
      for (int i = 0; i < LAT; i++) begin
        stg_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LAT; i++) begin
        stg_q[i] <= stg_d[i];
      end
    end
  end

  always_comb begin
    empty_o = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      if (stg_q[i].valid) empty_o = 1'b0;
    end
  end

  assign tag_o = stg_q[LAT-1];

endmodule

// File: rtl/cfa_grad_sched.sv
// cfa_grad_sched: raster scheduler for the CFA gradients datapath (5x5 windows).
// Ports: clk, rst (async low), frame_start/abort, pix_valid/ready, lb_wr_en,
// grad_start, res_valid/x/y, frame_done; win_count with CFA_GRAD_STATS_EN.
module cfa_grad_sched
  import cfa_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int GRAD_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic                       frame_abort,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic                       lb_wr_en,
  output logic                       grad_start,
  output logic                       res_valid,
  output logic [$clog2(IMG_W)-1:0]   res_x,
  output logic [$clog2(IMG_H)-1:0]   res_y,
  output logic                       frame_done
`ifdef CFA_GRAD_STATS_EN
  ,
  output logic [31:0]                win_count
`endif
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] COL_MIN  = XW'(CFA_WIN - 1);
  localparam logic [YW-1:0] ROW_MIN  = YW'(CFA_WIN - 1);

  sched_state_t state_q, state_d;

  logic [XW-1:0]     col_q, col_d;
  logic [YW-1:0]     row_q, row_d;
  logic              gs_q, gs_d;
  logic [CFA_CW-1:0] tx_q, tx_d;
  logic [CFA_CW-1:0] ty_q, ty_d;

  logic      last_pix;
  logic      win_hit;
  logic      start_ok;
  logic      pipe_empty;
  grad_tag_t tag_in;
  grad_tag_t tag_out;
  logic      unused_hi;

  assign pix_ready = (state_q == RUN);
  assign lb_wr_en  = pix_valid & pix_ready;
  assign start_ok  = (state_q == IDLE) & frame_start & ~frame_abort;

  assign last_pix = lb_wr_en &&
                    (col_q == COL_LAST) &&
                    (row_q == ROW_LAST);

  assign win_hit = lb_wr_en &&
                   (col_q >= COL_MIN) &&
                   (row_q >= ROW_MIN);

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    if (frame_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (frame_start) state_d = RUN;
        RUN:  if (last_pix) state_d = DRAIN;
        DRAIN: begin
          // gs_q is a window not yet loaded into the pipe
          if (pipe_empty && !gs_q) begin
            state_d    = IDLE;
            frame_done = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (start_ok) begin
      col_d = '0;
      row_d = '0;
    end else if (lb_wr_en) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    gs_d = win_hit & ~frame_abort;
    tx_d = tx_q;
    ty_d = ty_q;
    if (win_hit) begin
      tx_d = CFA_CW'(col_q) - CFA_CW'(CFA_HALF);
      ty_d = CFA_CW'(row_q) - CFA_CW'(CFA_HALF);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      gs_q    <= 1'b0;
      tx_q    <= '0;
      ty_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      gs_q    <= gs_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
    end
  end

  assign grad_start = gs_q;

  assign tag_in.valid = gs_q;
  assign tag_in.x     = tx_q;
  assign tag_in.y     = ty_q;

  cfa_tag_pipe #(
    .LAT (GRAD_LAT)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (frame_abort),
    .tag_i   (tag_in),
    .tag_o   (tag_out),
    .empty_o (pipe_empty)
  );

  assign res_valid = tag_out.valid;
  assign res_x     = tag_out.x[XW-1:0];
  assign res_y     = tag_out.y[YW-1:0];
  assign unused_hi = ^{tag_out.x[CFA_CW-1:XW], tag_out.y[CFA_CW-1:YW]};

`ifdef CFA_GRAD_STATS_EN
  logic [31:0] wc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wc_q <= '0;
    end else if (start_ok) begin
      wc_q <= '0;
    end else if (gs_q && (wc_q != '1)) begin
      wc_q <= wc_q + 1'b1;
    end
  end

  assign win_count = wc_q;
`endif

endmodule

// File: doc/cfa_grad_sched.md
# cfa_grad_sched

Raster scheduler that sequences the CFA `gradients` datapath across a frame. It accepts a pixel stream and drives the 5x5 line-buffer write strobe. It issues one `start` pulse per complete 5x5 window and tags each window with its centre coordinates through the datapath's fixed latency. It sits between the sensor pixel stream and the `gradients` instance and signals end-of-frame once the pipeline has drained.

## Interface
- `IMG_W`, 640: frame width in pixels; minimum 5.
- `IMG_H`, 480: frame height in pixels; minimum 5.
- `GRAD_LAT`, 2: cycles from `grad_start` to valid gradient outputs; minimum 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse that begins a frame; honoured only in IDLE.
- `frame_abort` in 1: abandons the current frame from any state.
- `pix_valid` in 1: an input pixel is present.
- `pix_ready` out 1: scheduler can accept a pixel (combinational: state==RUN).
- `lb_wr_en` out 1: `pix_valid & pix_ready`; line buffer / window shift strobe.
- `grad_start` out 1: registered; window complete, drives `gradients.start`.
- `res_valid` out 1: gradient outputs valid this cycle.
- `res_x` out clog2(IMG_W): centre column of the window reported by `res_valid`.
- `res_y` out clog2(IMG_H): centre row of the window reported by `res_valid`.
- `frame_done` out 1: one-cycle pulse when the frame has fully drained.
- `win_count` out 32: present only with `CFA_GRAD_STATS_EN`.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on `frame_start`. Entering RUN clears `col` and `row`.
- RUN, on each accept (`lb_wr_en`):
  - `col` increments.
  - At `col==IMG_W-1`, `col` wraps to 0 and `row` increments.
- Window rule: an accept at (`row`,`col`) with `row>=4 && col>=4` completes the window centred at (`row-2`,`col-2`). The scheduler then pulses `grad_start` on the next cycle and pushes a tag {x,y}.
- RUN -> DRAIN on the accept of (`IMG_H-1`,`IMG_W-1`). `pix_ready` drops the following cycle.
- DRAIN -> IDLE when the tag pipeline is empty and no `grad_start` is pending. `frame_done` pulses for one cycle on that transition.
- Tag pipeline: a `GRAD_LAT`-deep shift of {valid,x,y}. It is loaded on `grad_start` and shifts every cycle; there is no backpressure.
- `frame_abort`, any state:
  - Next state is IDLE.
  - Tags are flushed, so any `res_valid` pending is suppressed.
  - No `frame_done` pulse.
  - Abort has priority over `frame_start` in the same cycle.
- `frame_start` in RUN or DRAIN is ignored.
- `pix_valid` while not RUN is ignored; no counter change.
- Windows per frame: exactly (IMG_W-4)*(IMG_H-4). Border pixels produce no window.

## Timing
- Reset values:
  - State = IDLE.
  - `pix_ready`, `lb_wr_en`, `grad_start`, `res_valid` and `frame_done` = 0.
  - `res_x`, `res_y`, `col`, `row` = 0.
  - `win_count` = 0.
- `grad_start` occurs 1 cycle after the completing accept.
- `res_valid` occurs `GRAD_LAT` cycles after `grad_start`, i.e. GRAD_LAT+1 cycles after the accept.
- `frame_done` occurs 1 cycle after the last `res_valid`.
- Back-to-back accepts give back-to-back `grad_start` pulses; throughput is 1 window/cycle.
- Gaps in `pix_valid` hold all counters.
- `res_x`/`res_y` hold their last value when `res_valid`=0.

## Configuration
- `CFA_GRAD_STATS_EN` defined:
  - `win_count` port exists.
  - It increments on every `grad_start`.
  - It clears on `frame_start` accepted in IDLE and on reset, and saturates at 2^32-1.
- `CFA_GRAD_STATS_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `cfa_pkg`:
  - State enum `sched_state_t` {IDLE,RUN,DRAIN}.
  - Window size constant `CFA_WIN=5` and half-window `CFA_HALF=2`.
  - Tag struct `grad_tag_t` {valid,x,y}.
- One sub-module, `cfa_tag_pipe`: the parameterised GRAD_LAT-deep tag shift register with synchronous flush and an `empty` output.

## Test plan
- IMG_W=8, IMG_H=6, GRAD_LAT=3, `pix_valid` held high, 48 pixels:
  - exactly 8 `grad_start` pulses;
  - first `res_valid` at (x=2,y=2), last at (5,3);
  - `frame_done` 1 cycle after the last `res_valid`.
- Same frame with `pix_valid` toggling every other cycle: same 8 coordinates in raster order, each `res_valid` 4 cycles after its completing accept.
- `frame_abort` after 40 accepts:
  - state returns to IDLE with no further `res_valid` and no `frame_done`;
  - a new `frame_start` then yields a full, correct 8-window frame.
- `frame_start` pulsed mid-RUN and `pix_valid` held during IDLE: no counter change and no extra windows.
- IMG_W=IMG_H=5, GRAD_LAT=1: a single window at (2,2), with `res_valid` 2 cycles after the 25th accept.
- With `CFA_GRAD_STATS_EN`: `win_count`=8 after the frame; it returns to 0 on the next accepted `frame_start`.
